piece_write_mux_gen: RTL and testbench
======================================

Name: piece_write_mux_gen

Overview:
Parametrised successor of the active-piece write selector. It owns the registered "active piece" overlay plane that feeds the board merge and collision logic, and loads that plane on spawn, rotation and hold/swap. It adds edge-detected key actions, a hold slot and a once-per-piece swap lock. It sits between the game FSM, the keyboard keycode register, the rotation checker and the board/VGA merge.

Parameters:
COLS, 10, board width in cells (bits per row)
ROWS, 22, board height in rows, including hidden spawn rows
PIECE_ROWS, 2, rows occupied by a spawn-orientation shape
SPAWN_STATE, 3'b000, game-FSM encoding that triggers a spawn
KEY_ROTATE, 8'h1A, keycode that requests rotation
KEY_HOLD, 8'h06, keycode that requests hold/swap

Ports:
Clk  in  1  system clock
Reset_h  in  1  synchronous active-high reset
state  in  3  game FSM state
new_block  in  COLS x PIECE_ROWS  shape to spawn, row 0 = top
next_block  in  COLS x PIECE_ROWS  queued next shape, used when the hold slot is empty
next_rotation  in  COLS x ROWS  full-plane rotated candidate
keycode  in  8  current keyboard keycode, 0 = none
can_rotate  in  1  rotation checker approves next_rotation
can_swap  in  1  FSM permits a hold action this cycle
next_write  out  COLS x ROWS  registered active-piece plane
hold_shape  out  COLS x PIECE_ROWS  shape in the hold slot
hold_valid  out  1  hold slot occupied
swap_used  out  1  hold already used for the current piece
swap_pulse  out  1  one-cycle pulse, high for the cycle after a swap commits
consume_next  out  1  one-cycle pulse, high when next_block was consumed by a swap into an empty hold

Behaviour:
- Single clock domain. Reset is synchronous and active-high (Reset_h, sampled on posedge Clk).
- Reset values: plane all 0, hold_shape 0, hold_valid 0, swap_used 0, cur_shape 0, key_prev 0, and all pulses 0.
- Placement rule: shape row r goes to plane row ROWS-1-r for r in 0..PIECE_ROWS-1. All other plane rows are 0.
- Key edge: press = (keycode != 0) && (keycode != key_prev). key_prev <= keycode every cycle, including reset-exit cycles. A held key acts once.
- Priority per cycle, highest first: reset, spawn, swap, rotate, hold value.
- Spawn (state == SPAWN_STATE), applied every cycle the state is held:
  - plane <= placed new_block
  - cur_shape <= new_block
  - swap_used <= 0
  - key actions are ignored.
- Swap (press of KEY_HOLD, can_swap = 1, swap_used = 0, not spawn):
  - If hold_valid = 0: hold_shape <= cur_shape, plane <= placed next_block, cur_shape <= next_block, hold_valid <= 1, consume_next = 1 next cycle.
  - Else: exchange hold_shape and cur_shape, and plane <= placed old hold_shape.
  - In both cases swap_used <= 1 and swap_pulse = 1 next cycle.
  - A swap request with swap_used = 1 or can_swap = 0 is a no-op.
- Rotate (press of KEY_ROTATE, can_rotate = 1, not spawn, no swap this cycle): plane <= next_rotation verbatim. cur_shape is unchanged; hold stores spawn orientation.
- Otherwise all state holds.
- Latency: next_write, hold_* and swap_used reflect an action one cycle after the sampling edge. next_write is driven directly from the register, with no combinational input path.
- Reset mid-operation: clears hold and lock. A key held through reset does not fire on release of reset unless it differs from key_prev (0).

Optional Feature:
PIECE_HOLD_EN.
- Defined: hold/swap logic as above.
- Undefined: KEY_HOLD is ignored. hold_shape, hold_valid, swap_used, swap_pulse and consume_next are tied to 0. No hold registers are inferred. Spawn and rotate are unchanged.

Test Plan:
- Reset_h=1 for 2 cycles, then state=3'b000 with new_block={10'h030,10'h030} -> one cycle later next_write[21]=next_write[20]=10'h030 and rows 19..0 = 0.
- With state≠SPAWN_STATE, keycode=8'h1A held 5 cycles, can_rotate=1, next_rotation[5]=10'h1F0 -> plane loads once, row5=10'h1F0. The second press requires keycode to pass through 0 first.
- Rotate press with can_rotate=0 -> plane unchanged, no outputs toggle.
- Hold empty, cur=10'h038/10'h010, next_block=10'h0F0/10'h000, press 8'h06, can_swap=1 -> hold_shape=cur, hold_valid=1, consume_next and swap_pulse high 1 cycle, next_write[21]=10'h0F0. A second press is a no-op (swap_used=1).
- Spawn, then swap with hold_valid=1 -> plane shows old hold shape and hold receives the spawned shape. Simultaneous state=SPAWN_STATE and KEY_HOLD press -> spawn wins, swap_used=0.
- Build without PIECE_HOLD_EN, press 8'h06 -> plane unchanged, all hold outputs 0.

Source files
------------

// File: rtl/piece_write_mux_gen_if.sv
// piece_write_mux_gen_if: bundle between game FSM / keyboard / rotation
// checker (master) and the active-piece write selector (slave).
// Inputs to the selector:
//   state, new_block, next_block, next_rotation, keycode, can_rotate, can_swap
// Outputs from the selector:
//   next_write, hold_shape, hold_valid, swap_used, swap_pulse, consume_next
interface piece_write_mux_gen_if #(
  parameter int COLS       = 10,
  parameter int ROWS       = 22,
  parameter int PIECE_ROWS = 2
);
  logic [2:0]                      state;
  logic [PIECE_ROWS-1:0][COLS-1:0] new_block;
  logic [PIECE_ROWS-1:0][COLS-1:0] next_block;
  logic [ROWS-1:0][COLS-1:0]       next_rotation;
  logic [7:0]                      keycode;
  logic                            can_rotate;
  logic                            can_swap;
  logic [ROWS-1:0][COLS-1:0]       next_write;
  logic [PIECE_ROWS-1:0][COLS-1:0] hold_shape;
  logic                            hold_valid;
  logic                            swap_used;
  logic                            swap_pulse;
  logic                            consume_next;

  modport master (
    output state,
    output new_block,
    output next_block,
    output next_rotation,
    output keycode,
    output can_rotate,
    output can_swap,
    input  next_write,
    input  hold_shape,
    input  hold_valid,
    input  swap_used,
    input  swap_pulse,
    input  consume_next
  );

  modport slave (
    input  state,
    input  new_block,
    input  next_block,
    input  next_rotation,
    input  keycode,
    input  can_rotate,
    input  can_swap,
    output next_write,
    output hold_shape,
    output hold_valid,
    output swap_used,
    output swap_pulse,
    output consume_next
  );
endinterface

// File: rtl/piece_write_mux_gen.sv
// piece_write_mux_gen: owns the registered active-piece plane; loads it on
// spawn, rotation and (optional) hold/swap with edge-detected keys.
// Ports:
//   Clk      system clock
//   Reset_h  synchronous active-high reset
//   bus      piece_write_mux_gen_if.slave (see interface for signals)
// Optional feature macro: PIECE_HOLD_EN enables the hold slot, the
// once-per-piece swap lock and the swap_pulse / consume_next strobes.
// Without it those outputs are tied low and no hold state exists.
module piece_write_mux_gen #(
  parameter int         COLS        = 10,
  parameter int         ROWS        = 22,
  parameter int         PIECE_ROWS  = 2,
  parameter logic [2:0] SPAWN_STATE = 3'b000,
  parameter logic [7:0] KEY_ROTATE  = 8'h1A,
  parameter logic [7:0] KEY_HOLD    = 8'h06
) (
  input logic                  Clk,
  input logic                  Reset_h,
  piece_write_mux_gen_if.slave bus
);

  typedef logic [PIECE_ROWS-1:0][COLS-1:0] shape_t;
  typedef logic [ROWS-1:0][COLS-1:0]       plane_t;

  // Shape row r lands on plane row ROWS-1-r; all other rows are empty.
  function automatic plane_t place(input shape_t s);
    plane_t p;
    p = '0;
    for (int r = 0; r < PIECE_ROWS; r++) begin
      p[ROWS-1-r] = s[r];
    end
    return p;
  endfunction

  plane_t     plane_q;
  plane_t     plane_d;
  logic [7:0] key_prev;
  logic       press;
  logic       spawn;
  logic       rot_req;
  logic       rot_ok;

  // A key acts once: only on the cycle its code first appears.
  assign press   = (bus.keycode != 8'h00) &&
                   (bus.keycode != key_prev);
  assign spawn   = (bus.state == SPAWN_STATE);
  assign rot_req = press &&
                   (bus.keycode == KEY_ROTATE) &&
                   bus.can_rotate;

  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      plane_q  <= '0;
      key_prev <= '0;
    end else begin
      plane_q  <= plane_d;
      key_prev <= bus.keycode;
    end
  end

  assign bus.next_write = plane_q;

`ifdef PIECE_HOLD_EN

  shape_t cur_q;
  shape_t cur_d;
  shape_t hold_q;
  shape_t hold_d;
  logic   hv_q;
  logic   hv_d;
  logic   used_q;
  logic   used_d;
  logic   sp_q;
  logic   cn_q;
  logic   do_swap;

  // Spawn outranks swap, swap outranks rotate, so the three
  // select terms below are mutually exclusive.
  assign do_swap = !spawn && press &&
                   (bus.keycode == KEY_HOLD) &&
                   bus.can_swap && !used_q;
  assign rot_ok  = !spawn && !do_swap && rot_req;

  always_comb begin
    plane_d = plane_q;
    cur_d   = cur_q;
    hold_d  = hold_q;
    hv_d    = hv_q;
    used_d  = used_q;
    unique case (1'b1)
      spawn: begin
        plane_d = place(bus.new_block);
        cur_d   = bus.new_block;
        used_d  = 1'b0;
      end
      do_swap: begin
        used_d = 1'b1;
        hold_d = cur_q;
        if (!hv_q) begin
          // Empty slot: park current piece, pull the queued one.
          plane_d = place(bus.next_block);
          cur_d   = bus.next_block;
          hv_d    = 1'b1;
        end else begin
          plane_d = place(hold_q);
          cur_d   = hold_q;
        end
      end
      rot_ok: begin
        plane_d = bus.next_rotation;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      cur_q  <= '0;
      hold_q <= '0;
      hv_q   <= 1'b0;
      used_q <= 1'b0;
      sp_q   <= 1'b0;
      cn_q   <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      hold_q <= hold_d;
      hv_q   <= hv_d;
      used_q <= used_d;
      sp_q   <= do_swap;
      cn_q   <= do_swap && !hv_q;
    end
  end

  assign bus.hold_shape   = hold_q;
  assign bus.hold_valid   = hv_q;
  assign bus.swap_used    = used_q;
  assign bus.swap_pulse   = sp_q;
  assign bus.consume_next = cn_q;

`else

  logic unused_hold;

  assign rot_ok = !spawn && rot_req;

  always_comb begin
    plane_d = plane_q;
    unique case (1'b1)
      spawn: begin
        plane_d = place(bus.new_block);
      end
      rot_ok: begin
        plane_d = bus.next_rotation;
      end
      default: begin
      end
    endcase
  end

  // Hold inputs have no effect in this build.
  assign unused_hold = ^{bus.next_block,
                         bus.can_swap,
                         (bus.keycode == KEY_HOLD)};

  assign bus.hold_shape   = '0;
  assign bus.hold_valid   = 1'b0;
  assign bus.swap_used    = 1'b0;
  assign bus.swap_pulse   = 1'b0;
  assign bus.consume_next = 1'b0;

`endif

endmodule

// File: tb/tb_piece_write_mux_gen.sv
// tb_piece_write_mux_gen: table-driven directed bench for
// piece_write_mux_gen; hold expectations follow PIECE_HOLD_EN.
module tb_piece_write_mux_gen;

`ifdef PIECE_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef logic [1:0][9:0]  shape_t;
  typedef logic [21:0][9:0] plane_t;

  typedef struct {
    logic       rst;
    logic [2:0] st;
    shape_t     nb;
    shape_t     xb;
    plane_t     nr;
    logic [7:0] key;
    logic       cr;
    logic       cs;
    plane_t     ep;
    shape_t     eh;
    logic       ehv;
    logic       esu;
    logic       esp;
    logic       ecn;
  } vec_t;

  logic Clk;
  logic Reset_h;
  int   checks;
  int   errors;

  piece_write_mux_gen_if #(
    .COLS(10), .ROWS(22), .PIECE_ROWS(2)
  ) bus ();

  piece_write_mux_gen #(
    .COLS(10), .ROWS(22), .PIECE_ROWS(2),
    .SPAWN_STATE(3'b000),
    .KEY_ROTATE(8'h1A), .KEY_HOLD(8'h06)
  ) dut (
    .Clk(Clk),
    .Reset_h(Reset_h),
    .bus(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Row 0 (top) is the first argument.
  function automatic shape_t sh(input logic [9:0] top,
                                input logic [9:0] bot);
    shape_t s;
    s[0] = top;
    s[1] = bot;
    return s;
  endfunction

  function automatic vec_t mk(
    input logic rst, input logic [2:0] st,
    input shape_t nb, input shape_t xb,
    input int ridx, input logic [9:0] rval,
    input logic [7:0] key, input logic cr, input logic cs,
    input logic [9:0] e21, input logic [9:0] e20,
    input int eidx, input logic [9:0] eval,
    input shape_t eh, input logic ehv, input logic esu,
    input logic esp, input logic ecn);
    vec_t v;
    v.rst = rst; v.st = st; v.nb = nb; v.xb = xb;
    v.nr = '0;
    if (rval != 10'h0) v.nr[ridx] = rval;
    v.key = key; v.cr = cr; v.cs = cs;
    v.ep = '0;
    v.ep[21] = e21;
    v.ep[20] = e20;
    if (eval != 10'h0) v.ep[eidx] = eval;
    v.eh = eh; v.ehv = ehv; v.esu = esu;
    v.esp = esp; v.ecn = ecn;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    Reset_h           = v.rst;
    bus.state         = v.st;
    bus.new_block     = v.nb;
    bus.next_block    = v.xb;
    bus.next_rotation = v.nr;
    bus.keycode       = v.key;
    bus.can_rotate    = v.cr;
    bus.can_swap      = v.cs;
  endtask

  task automatic check(input string tag, input plane_t ep,
                       input shape_t eh, input logic ehv,
                       input logic esu, input logic esp,
                       input logic ecn);
    if (!HOLD) begin
      eh = '0; ehv = 0; esu = 0; esp = 0; ecn = 0;
    end
    checks++;
    if (bus.next_write !== ep) begin
      errors++;
      $display("FAIL %s next_write got %h want %h",
               tag, bus.next_write, ep);
    end
    checks++;
    if (bus.hold_shape !== eh) begin
      errors++;
      $display("FAIL %s hold_shape got %h want %h",
               tag, bus.hold_shape, eh);
    end
    checks++;
    if (bus.hold_valid !== ehv) begin
      errors++;
      $display("FAIL %s hold_valid got %b want %b",
               tag, bus.hold_valid, ehv);
    end
    checks++;
    if (bus.swap_used !== esu) begin
      errors++;
      $display("FAIL %s swap_used got %b want %b",
               tag, bus.swap_used, esu);
    end
    checks++;
    if (bus.swap_pulse !== esp) begin
      errors++;
      $display("FAIL %s swap_pulse got %b want %b",
               tag, bus.swap_pulse, esp);
    end
    checks++;
    if (bus.consume_next !== ecn) begin
      errors++;
      $display("FAIL %s consume_next got %b want %b",
               tag, bus.consume_next, ecn);
    end
  endtask

  vec_t tbl[26];

  initial begin
    shape_t z;
    shape_t a;
    shape_t b;
    shape_t c;
    shape_t nx;
    plane_t ep;
    checks = 0;
    errors = 0;
    z  = '0;
    a  = sh(10'h038, 10'h010);
    b  = sh(10'h078, 10'h078);
    c  = sh(10'h030, 10'h030);
    nx = sh(10'h0F0, 10'h000);

    // rst st nb xb ridx rval key cr cs | e21 e20 eidx eval eh hv su sp cn
    tbl[0]  = mk(1,1,z,z,0,0,8'h00,0,0, 0,0,0,0, z,0,0,0,0);
    tbl[1]  = mk(1,1,z,z,0,0,8'h00,0,0, 0,0,0,0, z,0,0,0,0);
    tbl[2]  = mk(0,0,c,z,0,0,8'h00,0,0,
                 10'h030,10'h030,0,0, z,0,0,0,0);
    tbl[3]  = mk(0,1,z,z,5,10'h1F0,8'h1A,1,0,
                 0,0,5,10'h1F0, z,0,0,0,0);
    tbl[4]  = mk(0,1,z,z,7,10'h3FF,8'h1A,1,0,
                 0,0,5,10'h1F0, z,0,0,0,0);
    tbl[5]  = tbl[4];
    tbl[6]  = tbl[4];
    tbl[7]  = tbl[4];
    tbl[8]  = mk(0,1,z,z,7,10'h3FF,8'h00,1,0,
                 0,0,5,10'h1F0, z,0,0,0,0);
    tbl[9]  = mk(0,1,z,z,7,10'h3FF,8'h1A,0,0,
                 0,0,5,10'h1F0, z,0,0,0,0);
    tbl[10] = tbl[8];
    tbl[11] = mk(0,1,z,z,7,10'h3FF,8'h1A,1,0,
                 0,0,7,10'h3FF, z,0,0,0,0);
    tbl[12] = mk(0,0,a,z,0,0,8'h00,0,0,
                 10'h038,10'h010,0,0, z,0,0,0,0);
    tbl[13] = mk(0,1,z,nx,0,0,8'h06,0,1,
                 HOLD ? 10'h0F0 : 10'h038,
                 HOLD ? 10'h000 : 10'h010,0,0, a,1,1,1,1);
    tbl[14] = mk(0,1,z,nx,0,0,8'h00,0,1,
                 HOLD ? 10'h0F0 : 10'h038,
                 HOLD ? 10'h000 : 10'h010,0,0, a,1,1,0,0);
    tbl[15] = mk(0,1,z,sh(10'h3C0,10'h3C0),0,0,8'h06,0,1,
                 HOLD ? 10'h0F0 : 10'h038,
                 HOLD ? 10'h000 : 10'h010,0,0, a,1,1,0,0);
    tbl[16] = tbl[14];
    tbl[17] = mk(0,0,b,z,0,0,8'h00,0,1,
                 10'h078,10'h078,0,0, a,1,0,0,0);
    tbl[18] = mk(0,1,z,z,0,0,8'h06,0,1,
                 HOLD ? 10'h038 : 10'h078,
                 HOLD ? 10'h010 : 10'h078,0,0, b,1,1,1,0);
    tbl[19] = mk(0,1,z,z,0,0,8'h00,0,1,
                 HOLD ? 10'h038 : 10'h078,
                 HOLD ? 10'h010 : 10'h078,0,0, b,1,1,0,0);
    tbl[20] = mk(0,0,c,z,0,0,8'h06,0,1,
                 10'h030,10'h030,0,0, b,1,0,0,0);
    tbl[21] = mk(0,1,z,z,0,0,8'h06,0,1,
                 10'h030,10'h030,0,0, b,1,0,0,0);
    tbl[22] = mk(0,1,z,z,0,0,8'h00,0,1,
                 10'h030,10'h030,0,0, b,1,0,0,0);
    tbl[23] = mk(0,1,z,z,0,0,8'h06,0,0,
                 10'h030,10'h030,0,0, b,1,0,0,0);
    tbl[24] = mk(1,1,z,z,0,0,8'h1A,1,1, 0,0,0,0, z,0,0,0,0);
    tbl[25] = mk(0,1,z,z,3,10'h00F,8'h1A,1,0,
                 0,0,3,10'h00F, z,0,0,0,0);

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i]);
      @(posedge Clk);
      #1;
      check($sformatf("v%0d", i), tbl[i].ep, tbl[i].eh,
            tbl[i].ehv, tbl[i].esu, tbl[i].esp, tbl[i].ecn);
    end

    // Spawn held over several cycles reloads the plane every cycle.
    Reset_h        = 1'b0;
    bus.state      = 3'b000;
    bus.keycode    = 8'h00;
    bus.can_rotate = 1'b0;
    bus.can_swap   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.new_block = sh(10'h001 << k, 10'h200 >> k);
      @(posedge Clk);
      #1;
      ep = '0;
      ep[21] = 10'h001 << k;
      ep[20] = 10'h200 >> k;
      check($sformatf("spawn_hold%0d", k), ep, z, 0, 0, 0, 0);
    end

    // Rotate press while spawning is ignored and does not re-fire later.
    bus.keycode   = 8'h1A;
    bus.can_rotate = 1'b1;
    bus.next_rotation = '0;
    bus.next_rotation[9] = 10'h155;
    @(posedge Clk);
    #1;
    check("spawn_vs_rot", ep, z, 0, 0, 0, 0);
    bus.state = 3'b010;
    @(posedge Clk);
    #1;
    check("rot_after_spawn", ep, z, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
